// File: rtl/counter_ctrl.sv
// Run sequencer for the binary counter datapath: config latch, prescaled tick, one-shot/auto-reload control.
// Optional sticky interrupt output enabled by defining COUNTER_CTRL_IRQ_EN.
module counter_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_load,
  input  logic [WIDTH-1:0]   cfg_tc,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_mode,
  input  logic               cfg_dir,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
`ifdef COUNTER_CTRL_IRQ_EN
  input  logic               irq_clr,
  output logic               irq,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               cnt_tick,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               cfg_err,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   count_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]   tc_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic               mode_reg;
  logic               dir_reg;

  logic               cfg_ok;
  logic [WIDTH-1:0]   tc_eff;
  logic               dir_eff;
  logic [WIDTH-1:0]   start_val;
  logic [WIDTH-1:0]   reload_val;
  logic               terminal;
  logic               term_tick;
  logic               done_set;
  logic               wrap_set;

  // Config is writable only while no run is active; a same-edge start sees the new values.
  always_comb begin
    cfg_ok     = cfg_load && (state_q == S_IDLE || state_q == S_DONE);
    tc_eff     = cfg_ok ? cfg_tc : tc_reg;
    dir_eff    = cfg_ok ? cfg_dir : dir_reg;
    start_val  = dir_eff ? tc_eff : '0;
    reload_val = dir_reg ? tc_reg : '0;
    terminal   = dir_reg ? (count_q == '0) : (count_q == tc_reg);
    cnt_tick   = (state_q == S_RUN) && !stop && !start && !hold && (presc_cnt == presc_reg);
    term_tick  = cnt_tick && terminal;
    done_set   = term_tick && !mode_reg;
    wrap_set   = term_tick && mode_reg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_cnt <= '0;
      tc_reg    <= '1;
      presc_reg <= '0;
      mode_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= done_set;
      wrap    <= wrap_set;
      cfg_err <= cfg_load && (state_q == S_RUN || state_q == S_HOLD);
      if (cfg_ok) begin
        tc_reg    <= cfg_tc;
        presc_reg <= cfg_presc;
        mode_reg  <= cfg_mode;
        dir_reg   <= cfg_dir;
      end
      if (stop) begin
        state_q   <= S_IDLE;
        count_q   <= '0;
        presc_cnt <= '0;
        busy      <= 1'b0;
      end else if (start) begin
        state_q   <= S_RUN;
        count_q   <= start_val;
        presc_cnt <= '0;
        busy      <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: busy <= 1'b0;
          S_RUN: begin
            if (hold) begin
              state_q <= S_HOLD;
            end else if (cnt_tick) begin
              presc_cnt <= '0;
              if (terminal) begin
                if (mode_reg) begin
                  count_q <= reload_val;
                end else begin
                  state_q <= S_DONE;
                  busy    <= 1'b0;
                end
              end else if (dir_reg) begin
                count_q <= count_q - WIDTH'(1);
              end else begin
                count_q <= count_q + WIDTH'(1);
              end
            end else begin
              presc_cnt <= presc_cnt + PRESC_W'(1);
            end
          end
          S_HOLD: begin
            if (!hold) state_q <= S_RUN;
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef COUNTER_CTRL_IRQ_EN
  // Sticky interrupt: a new event wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq <= 1'b0;
    end else if (done_set || wrap_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl; irq checks compile in with COUNTER_CTRL_IRQ_EN.
module tb_counter_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cfg_load;
  logic [3:0] cfg_tc;
  logic [7:0] cfg_presc;
  logic       cfg_mode;
  logic       cfg_dir;
  logic       start;
  logic       stop;
  logic       hold;
  logic [3:0] count;
  logic       cnt_tick;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       cfg_err;
  logic [1:0] state;
`ifdef COUNTER_CTRL_IRQ_EN
  logic       irq_clr;
  logic       irq;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  counter_ctrl #(.WIDTH(4), .PRESC_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_load(cfg_load), .cfg_tc(cfg_tc), .cfg_presc(cfg_presc),
    .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
    .start(start), .stop(stop), .hold(hold),
`ifdef COUNTER_CTRL_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .count(count), .cnt_tick(cnt_tick), .busy(busy), .done(done),
    .wrap(wrap), .cfg_err(cfg_err), .state(state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_cfg(input logic [3:0] tc, input logic [7:0] ps, input logic md, input logic dr);
    cfg_load = 1'b1; cfg_tc = tc; cfg_presc = ps; cfg_mode = md; cfg_dir = dr;
  endtask

  task automatic test_reset();
    RST = 1'b1; cfg_load = 0; cfg_tc = 0; cfg_presc = 0; cfg_mode = 0; cfg_dir = 0;
    start = 0; stop = 0; hold = 0;
`ifdef COUNTER_CTRL_IRQ_EN
    irq_clr = 0;
`endif
    step(); step();
    RST = 1'b0;
    #1;
    check_cnt++;
    if ({count, state, busy, done, wrap, cfg_err, cnt_tick} !== 11'd0)
      $display("FAIL reset_outputs: count=%0d state=%0d busy=%b done=%b wrap=%b cfg_err=%b tick=%b, required all 0",
               count, state, busy, done, wrap, cfg_err, cnt_tick);
    else pass_cnt++;
`ifdef COUNTER_CTRL_IRQ_EN
    check_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: irq=%b required 0", irq); else pass_cnt++;
`endif
    // Default terminal count is all ones: 16 ticks to completion.
    start = 1'b1; step(); start = 1'b0; #1;
    check_cnt++;
    if (state !== 2'd1 || count !== 4'd0 || cnt_tick !== 1'b1)
      $display("FAIL reset_run_start: state=%0d count=%0d tick=%b, required 1/0/1", state, count, cnt_tick);
    else pass_cnt++;
    for (int i = 1; i <= 15; i++) begin
      step();
      check_cnt++;
      if (count !== 4'(i)) $display("FAIL reset_run_count: count=%0d required %0d", count, i);
      else pass_cnt++;
    end
    step();
    check_cnt++;
    if (state !== 2'd3 || done !== 1'b1 || count !== 4'd15)
      $display("FAIL reset_run_done: state=%0d done=%b count=%0d, required 3/1/15", state, done, count);
    else pass_cnt++;
    step();
    check_cnt++;
    if (state !== 2'd0 || done !== 1'b0 || count !== 4'd15)
      $display("FAIL reset_run_idle: state=%0d done=%b count=%0d, required 0/0/15", state, done, count);
    else pass_cnt++;
  endtask

  task automatic test_oneshot_up();
    load_cfg(4'd5, 8'd0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0; cfg_load = 1'b0;
    check_cnt++;
    if (count !== 4'd0 || state !== 2'd1 || busy !== 1'b1)
      $display("FAIL oneshot_start: count=%0d state=%0d busy=%b, required 0/1/1", count, state, busy);
    else pass_cnt++;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_cnt++;
      if (count !== 4'(i)) $display("FAIL oneshot_count: count=%0d required %0d", count, i);
      else pass_cnt++;
    end
    step();
    check_cnt++;
    if (state !== 2'd3 || done !== 1'b1 || count !== 4'd5 || busy !== 1'b0)
      $display("FAIL oneshot_done: state=%0d done=%b count=%0d busy=%b, required 3/1/5/0", state, done, count, busy);
    else pass_cnt++;
    step();
    check_cnt++;
    if (state !== 2'd0 || done !== 1'b0 || count !== 4'd5)
      $display("FAIL oneshot_idle: state=%0d done=%b count=%0d, required 0/0/5", state, done, count);
    else pass_cnt++;
  endtask

  task automatic test_autoreload_down();
    load_cfg(4'd3, 8'd2, 1'b1, 1'b1);
    step(); cfg_load = 1'b0;
    start = 1'b1; step(); start = 1'b0; #1;
    for (int n = 0; n < 12; n++) begin
      check_cnt++;
      if (count !== 4'(3 - n / 3) || wrap !== 1'b0 || busy !== 1'b1)
        $display("FAIL reload_count: sample=%0d count=%0d wrap=%b busy=%b, required %0d/0/1", n, count, wrap, busy, 3 - n / 3);
      else pass_cnt++;
      check_cnt++;
      if (cnt_tick !== (n % 3 == 2))
        $display("FAIL reload_tick: sample=%0d tick=%b required %b", n, cnt_tick, (n % 3 == 2));
      else pass_cnt++;
      step();
    end
    check_cnt++;
    if (wrap !== 1'b1 || count !== 4'd3 || state !== 2'd1 || busy !== 1'b1)
      $display("FAIL reload_wrap: wrap=%b count=%0d state=%0d busy=%b, required 1/3/1/1", wrap, count, state, busy);
    else pass_cnt++;
    step();
    check_cnt++;
    if (wrap !== 1'b0 || count !== 4'd3)
      $display("FAIL reload_after: wrap=%b count=%0d, required 0/3", wrap, count);
    else pass_cnt++;
    stop = 1'b1; step(); stop = 1'b0;
    check_cnt++;
    if (state !== 2'd0 || count !== 4'd0 || busy !== 1'b0)
      $display("FAIL reload_stop: state=%0d count=%0d busy=%b, required 0/0/0", state, count, busy);
    else pass_cnt++;
  endtask

  task automatic test_hold_stop();
    load_cfg(4'd9, 8'd0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0; cfg_load = 1'b0;
    step(); step();
    check_cnt++;
    if (count !== 4'd2) $display("FAIL hold_pre: count=%0d required 2", count); else pass_cnt++;
    hold = 1'b1; #1;
    check_cnt++;
    if (cnt_tick !== 1'b0) $display("FAIL hold_tick: tick=%b required 0", cnt_tick); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      check_cnt++;
      if (state !== 2'd2 || count !== 4'd2 || busy !== 1'b1)
        $display("FAIL hold_frozen: cycle=%0d state=%0d count=%0d busy=%b, required 2/2/1", i, state, count, busy);
      else pass_cnt++;
    end
    hold = 1'b0; step();
    check_cnt++;
    if (state !== 2'd1 || count !== 4'd2)
      $display("FAIL hold_release: state=%0d count=%0d, required 1/2", state, count);
    else pass_cnt++;
    step();
    check_cnt++;
    if (count !== 4'd3) $display("FAIL hold_resume: count=%0d required 3", count); else pass_cnt++;
    stop = 1'b1; step(); stop = 1'b0;
    check_cnt++;
    if (state !== 2'd0 || count !== 4'd0 || busy !== 1'b0)
      $display("FAIL hold_stop: state=%0d count=%0d busy=%b, required 0/0/0", state, count, busy);
    else pass_cnt++;
  endtask

  task automatic test_cfg_reject();
    load_cfg(4'd9, 8'd0, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0; cfg_load = 1'b0;
    load_cfg(4'd2, 8'd0, 1'b0, 1'b0);
    step(); cfg_load = 1'b0;
    check_cnt++;
    if (cfg_err !== 1'b1 || count !== 4'd1)
      $display("FAIL reject_err: cfg_err=%b count=%0d, required 1/1", cfg_err, count);
    else pass_cnt++;
    step();
    check_cnt++;
    if (cfg_err !== 1'b0 || count !== 4'd2)
      $display("FAIL reject_pulse: cfg_err=%b count=%0d, required 0/2", cfg_err, count);
    else pass_cnt++;
    // Old tc=9 / auto-reload must still apply.
    for (int i = 3; i <= 9; i++) step();
    check_cnt++;
    if (count !== 4'd9 || state !== 2'd1)
      $display("FAIL reject_keep_tc: count=%0d state=%0d, required 9/1", count, state);
    else pass_cnt++;
    step();
    check_cnt++;
    if (wrap !== 1'b1 || count !== 4'd0 || state !== 2'd1)
      $display("FAIL reject_keep_mode: wrap=%b count=%0d state=%0d, required 1/0/1", wrap, count, state);
    else pass_cnt++;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check_cnt++;
    if (state !== 2'd0 || count !== 4'd0 || busy !== 1'b0)
      $display("FAIL start_stop_priority: state=%0d count=%0d busy=%b, required 0/0/0", state, count, busy);
    else pass_cnt++;
  endtask

  task automatic test_tc_zero();
    load_cfg(4'd0, 8'd0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0; cfg_load = 1'b0; #1;
    check_cnt++;
    if (state !== 2'd1 || count !== 4'd0 || cnt_tick !== 1'b1)
      $display("FAIL tc0_run: state=%0d count=%0d tick=%b, required 1/0/1", state, count, cnt_tick);
    else pass_cnt++;
    step();
    check_cnt++;
    if (state !== 2'd3 || done !== 1'b1 || count !== 4'd0)
      $display("FAIL tc0_done: state=%0d done=%b count=%0d, required 3/1/0", state, done, count);
    else pass_cnt++;
    step();
    check_cnt++;
    if (state !== 2'd0 || done !== 1'b0)
      $display("FAIL tc0_idle: state=%0d done=%b, required 0/0", state, done);
    else pass_cnt++;
  endtask

`ifdef COUNTER_CTRL_IRQ_EN
  task automatic test_irq();
    load_cfg(4'd1, 8'd0, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0; cfg_load = 1'b0;
    step();
    check_cnt++;
    if (count !== 4'd1 || irq !== 1'b0)
      $display("FAIL irq_idle: count=%0d irq=%b, required 1/0", count, irq);
    else pass_cnt++;
    step();
    check_cnt++;
    if (wrap !== 1'b1 || irq !== 1'b1)
      $display("FAIL irq_set: wrap=%b irq=%b, required 1/1", wrap, irq);
    else pass_cnt++;
    step();
    check_cnt++;
    if (irq !== 1'b1 || count !== 4'd1)
      $display("FAIL irq_sticky: irq=%b count=%0d, required 1/1", irq, count);
    else pass_cnt++;
    irq_clr = 1'b1; step();
    check_cnt++;
    if (wrap !== 1'b1 || irq !== 1'b1)
      $display("FAIL irq_set_wins: wrap=%b irq=%b, required 1/1", wrap, irq);
    else pass_cnt++;
    step(); irq_clr = 1'b0;
    check_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clear: irq=%b required 0", irq); else pass_cnt++;
    stop = 1'b1; step(); stop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot_up();
    test_autoreload_down();
    test_hold_stop();
    test_cfg_reject();
    test_tc_zero();
`ifdef COUNTER_CTRL_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
